// File: rtl/raster_scan_gen.sv
// ============================================================================
// Module      : raster_scan_gen
// Description : Raster-order pixel source with x/y, background colour and
//               valid/sof/eol framing. Define RASTER_TEST_PATTERN_EN to get
//               8 vertical colour bars on active pixels instead of BG_*.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_scan_gen #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          H_BLANK  = 160,
    parameter int          V_BLANK  = 45,
    parameter logic [7:0]  BG_R     = 8'h00,
    parameter logic [7:0]  BG_G     = 8'h00,
    parameter logic [7:0]  BG_B     = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] x,
    output logic [11:0] y,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        valid,
    output logic        sof,
    output logic        eol
);

    localparam logic [9:0]  c_h_active = 10'(H_ACTIVE);
    localparam logic [9:0]  c_h_eol    = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  c_h_last   = 10'(H_ACTIVE + H_BLANK - 1);
    localparam logic [10:0] c_v_active = 11'(V_ACTIVE);
    localparam logic [10:0] c_v_last   = 11'(V_ACTIVE + V_BLANK - 1);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        line_end;
    logic        active;
    logic [7:0]  act_r, act_g, act_b;

    assign line_end = (h_cnt_q == c_h_last);
    assign active   = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active);

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (line_end) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == c_v_last) ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 11'd0;
        end else if (en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

`ifdef RASTER_TEST_PATTERN_EN
    localparam logic [9:0] c_bar_last = 10'(H_ACTIVE / 8 - 1);

    // Bar index tracks h_cnt_q; bar 7 absorbs any remainder and the blanking.
    logic [2:0] bar_q, bar_d;
    logic [9:0] bar_cnt_q, bar_cnt_d;

    always_comb begin
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        if (line_end) begin
            bar_d     = 3'd0;
            bar_cnt_d = 10'd0;
        end else if (bar_q != 3'd7) begin
            if (bar_cnt_q == c_bar_last) begin
                bar_d     = bar_q + 3'd1;
                bar_cnt_d = 10'd0;
            end else begin
                bar_cnt_d = bar_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bar_q     <= 3'd0;
            bar_cnt_q <= 10'd0;
        end else if (en) begin
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
        end
    end

    assign act_r = {8{bar_q[2]}};
    assign act_g = {8{bar_q[1]}};
    assign act_b = {8{bar_q[0]}};
`else
    assign act_r = BG_R;
    assign act_g = BG_G;
    assign act_b = BG_B;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x     <= 11'd0;
            y     <= 12'd0;
            r     <= 8'd0;
            g     <= 8'd0;
            b     <= 8'd0;
            valid <= 1'b0;
            sof   <= 1'b0;
            eol   <= 1'b0;
        end else if (en) begin
            x     <= {1'b0, h_cnt_q};
            y     <= {1'b0, v_cnt_q};
            r     <= active ? act_r : 8'd0;
            g     <= active ? act_g : 8'd0;
            b     <= active ? act_b : 8'd0;
            valid <= active;
            sof   <= active && (h_cnt_q == 10'd0) && (v_cnt_q == 11'd0);
            eol   <= active && (h_cnt_q == c_h_eol);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_raster_scan_gen.sv
// ============================================================================
// Module      : tb_raster_scan_gen
// Description : Self-checking bench for raster_scan_gen against a linear
//               pixel-index reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_raster_scan_gen;

    localparam int HA = 32;
    localparam int VA = 32;
    localparam int HB = 4;
    localparam int VB = 2;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;
    localparam int NPIX = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] x;
    logic [11:0] y;
    logic [7:0]  r, g, b;
    logic        valid, sof, eol;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the next pixel to emit is a linear index into the frame.
    int   m_p;
    int   e_x, e_y, e_r, e_g, e_b;
    logic e_valid, e_sof, e_eol;

    raster_scan_gen #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .V_BLANK  (VB),
        .BG_R     (8'h10),
        .BG_G     (8'h20),
        .BG_B     (8'h30)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .x     (x),
        .y     (y),
        .r     (r),
        .g     (g),
        .b     (b),
        .valid (valid),
        .sof   (sof),
        .eol   (eol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p = 0;
        e_x = 0; e_y = 0; e_r = 0; e_g = 0; e_b = 0;
        e_valid = 1'b0; e_sof = 1'b0; e_eol = 1'b0;
    endtask

    task automatic model_emit();
        int xx, yy, bar;
        logic act;
        xx  = m_p % HT;
        yy  = m_p / HT;
        act = (xx < HA) && (yy < VA);
        e_x = xx;
        e_y = yy;
        e_valid = act;
        e_sof = act && (m_p == 0);
        e_eol = act && (xx == HA - 1);
`ifdef RASTER_TEST_PATTERN_EN
        bar = xx / (HA / 8);
        if (bar > 7) bar = 7;
        e_r = ((bar & 4) != 0) ? 8'hFF : 8'h00;
        e_g = ((bar & 2) != 0) ? 8'hFF : 8'h00;
        e_b = ((bar & 1) != 0) ? 8'hFF : 8'h00;
`else
        bar = 0;
        e_r = 8'h10 + bar; e_g = 8'h20; e_b = 8'h30;
`endif
        if (!act) begin
            e_r = 0; e_g = 0; e_b = 0;
        end
        m_p = (m_p + 1) % NPIX;
    endtask

    // Apply inputs for one clock, update the model, check at the falling edge.
    task automatic step(input logic rst_v, input logic en_v);
        rst_n = rst_v;
        en    = en_v;
        @(posedge clk);
        if (!rst_v)     model_reset();
        else if (en_v)  model_emit();
        @(negedge clk);
        chk("x",     32'(x),     32'(e_x));
        chk("y",     32'(y),     32'(e_y));
        chk("r",     32'(r),     32'(e_r));
        chk("g",     32'(g),     32'(e_g));
        chk("b",     32'(b),     32'(e_b));
        chk("valid", 32'(valid), 32'(e_valid));
        chk("sof",   32'(sof),   32'(e_sof));
        chk("eol",   32'(eol),   32'(e_eol));
    endtask

    task automatic run_to(input int tx, input int ty);
        int guard = 0;
        while (!(e_x == tx && e_y == ty && m_p != 0) && guard < 2 * NPIX) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("run_to_bound", 32'(guard < 2 * NPIX), 32'd1);
    endtask

    initial begin
        int cnt_valid, cnt_eol, cnt_sof;
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held for three cycles with en high.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // One full frame starting at (0,0).
        cnt_valid = 0; cnt_eol = 0; cnt_sof = 0;
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, 1'b1);
            if (i == 0) chk("first_sof", 32'(sof), 32'd1);
            cnt_valid += int'(valid);
            cnt_eol   += int'(eol);
            cnt_sof   += int'(sof);
        end
        chk("frame_valid", 32'(cnt_valid), 32'd1024);
        chk("frame_eol",   32'(cnt_eol),   32'd32);
        chk("frame_sof",   32'(cnt_sof),   32'd1);
        step(1'b1, 1'b1);
        chk("wrap_sof", {20'd0, x, sof}, 32'd1);

        // Stall at (17,5) then resume.
        run_to(17, 5);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("hold_x", 32'(x), 32'd17);
        step(1'b1, 1'b1);
        chk("resume_x", 32'(x), 32'd18);
        chk("resume_y", 32'(y), 32'd5);

        // Mid-frame reset at (20,12).
        run_to(20, 12);
        step(1'b0, 1'b1);
        chk("midrst_x", 32'(x), 32'd0);
        step(1'b1, 1'b1);
        chk("midrst_sof", 32'(sof), 32'd1);

        // Random enable with occasional reset.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 599) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
